// File: rtl/conv_ctrl_pkg.sv
// Shared definitions for the 3x3 convolution controller: kernel geometry,
// FSM state encoding and the latched run configuration.
package conv_ctrl_pkg;
  localparam int KDIM  = 3;
  localparam int KTAPS = KDIM * KDIM;
  localparam int TAP_W = $clog2(KTAPS);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WT_REQ, ST_WT_WAIT, ST_IFM_REQ, ST_IFM_WAIT, ST_WRITE, ST_DONE
  } state_t;

  typedef struct packed {
    logic [31:0] ifm;
    logic [31:0] wt;
    logic [31:0] ofm;
  } offsets_t;
endpackage

// File: rtl/conv_ctrl_if.sv
// Single-port memory request/response bus between the conv engine and memory.
interface conv_ctrl_if;
  logic        req_valid_o;
  logic        req_ready_i;
  logic [31:0] req_addr_o;
  logic        req_we_o;
  logic [31:0] req_wdata_o;
  logic        resp_valid_i;
  logic [31:0] resp_data_i;

  modport master (
    output req_valid_o, req_addr_o, req_we_o, req_wdata_o,
    input  req_ready_i, resp_valid_i, resp_data_i
  );
  modport slave (
    input  req_valid_o, req_addr_o, req_we_o, req_wdata_o,
    output req_ready_i, resp_valid_i, resp_data_i
  );
endinterface

// File: rtl/conv_window_cnt.sv
// Output-pixel / kernel-tap walker: row-major pixels, row-major taps,
// zero-padding detection and flat ifm/ofm element indices.
module conv_window_cnt import conv_ctrl_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             step_tap,
  input  logic             step_pix,
  input  logic [7:0]       n,
  output logic [TAP_W-1:0] tap,
  output logic             pad,
  output logic             last_tap,
  output logic             last_pix,
  output logic [31:0]      ifm_idx,
  output logic [31:0]      ofm_idx
);
  logic [7:0]  r, c;
  logic [1:0]  kr, kc;
  logic [31:0] i_row, j_col;
  logic [7:0]  n_m1;

  localparam logic [1:0] KLAST = 2'(KDIM - 1);

  assign n_m1 = n - 8'd1;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r <= '0; c <= '0; kr <= '0; kc <= '0;
    end else if (step_pix) begin
      kr <= '0;
      kc <= '0;
      if (c == n_m1) begin
        c <= '0;
        r <= r + 8'd1;
      end else begin
        c <= c + 8'd1;
      end
    end else if (step_tap) begin
      if (kc == KLAST) begin
        kc <= '0;
        kr <= kr + 2'd1;
      end else begin
        kc <= kc + 2'd1;
      end
    end
  end

  // kr/kc = 0..2 map to dr/dc = -1..+1; padded taps produce a don't-care index
  assign i_row    = 32'(r) + 32'(kr) - 32'd1;
  assign j_col    = 32'(c) + 32'(kc) - 32'd1;
  assign ifm_idx  = i_row * 32'(n) + j_col;
  assign ofm_idx  = 32'(r) * 32'(n) + 32'(c);
  assign tap      = TAP_W'(kr) * TAP_W'(KDIM) + TAP_W'(kc);
  assign pad      = (kr == 2'd0 && r == 8'd0) || (kr == KLAST && r == n_m1) ||
                    (kc == 2'd0 && c == 8'd0) || (kc == KLAST && c == n_m1);
  assign last_tap = (kr == KLAST) && (kc == KLAST);
  assign last_pix = (r == n_m1) && (c == n_m1);
endmodule

// File: rtl/conv_ctrl.sv
// 3x3 zero-padded convolution engine: loads the kernel, then for each output
// pixel fetches its in-map taps one at a time and writes the 32-bit sum.
module conv_ctrl import conv_ctrl_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] fm_dim_i,
  input  logic [31:0] ifm_offset_i,
  input  logic [31:0] wt_offset_i,
  input  logic [31:0] ofm_offset_i,
  output logic        idle_o,
  output logic        done_o,
  conv_ctrl_if.master mem
);
  state_t           state, state_n;
  offsets_t         offs;
  logic [7:0]       n;
  logic [TAP_W-1:0] widx;
  logic [31:0]      w [KTAPS];
  logic [31:0]      acc;

  logic             hs, resp, accept;
  logic             step_tap, step_pix;
  logic [TAP_W-1:0] tap;
  logic             pad, last_tap, last_pix;
  logic [31:0]      ifm_idx, ofm_idx;
  logic             unused_dim_bits;

  assign unused_dim_bits = ^fm_dim_i[31:8];
  assign hs     = mem.req_valid_o && mem.req_ready_i;
  assign resp   = mem.resp_valid_i;
  assign accept = (state == ST_IDLE || state == ST_DONE) && start_i;

  assign step_tap = !last_tap && ((state == ST_IFM_REQ && pad) ||
                                  (state == ST_IFM_WAIT && resp));
  assign step_pix = (state == ST_WRITE) && hs && !last_pix;

  conv_window_cnt u_win (
    .clk(clk), .rst(rst), .clear(accept), .step_tap(step_tap), .step_pix(step_pix),
    .n(n), .tap(tap), .pad(pad), .last_tap(last_tap), .last_pix(last_pix),
    .ifm_idx(ifm_idx), .ofm_idx(ofm_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE, ST_DONE: if (start_i) state_n = (fm_dim_i[7:0] == 8'd0) ? ST_DONE : ST_WT_REQ;
      ST_WT_REQ:  if (hs) state_n = ST_WT_WAIT;
      ST_WT_WAIT: if (resp) state_n = (widx == TAP_W'(KTAPS - 1)) ? ST_IFM_REQ : ST_WT_REQ;
      // padded taps are skipped without touching the bus
      ST_IFM_REQ: begin
        if (pad)     state_n = last_tap ? ST_WRITE : ST_IFM_REQ;
        else if (hs) state_n = ST_IFM_WAIT;
      end
      ST_IFM_WAIT: if (resp) state_n = last_tap ? ST_WRITE : ST_IFM_REQ;
      ST_WRITE:    if (hs) state_n = last_pix ? ST_DONE : ST_IFM_REQ;
      default:     state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    idle_o          = (state == ST_IDLE) || (state == ST_DONE);
    done_o          = (state == ST_DONE);
    mem.req_valid_o = 1'b0;
    mem.req_we_o    = 1'b0;
    mem.req_addr_o  = '0;
    mem.req_wdata_o = '0;
    case (state)
      ST_WT_REQ: begin
        mem.req_valid_o = 1'b1;
        mem.req_addr_o  = offs.wt + (32'(widx) << 2);
      end
      ST_IFM_REQ: if (!pad) begin
        mem.req_valid_o = 1'b1;
        mem.req_addr_o  = offs.ifm + (ifm_idx << 2);
      end
      ST_WRITE: begin
        mem.req_valid_o = 1'b1;
        mem.req_we_o    = 1'b1;
        mem.req_addr_o  = offs.ofm + (ofm_idx << 2);
        mem.req_wdata_o = acc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      offs <= '0;
      n    <= '0;
      widx <= '0;
      acc  <= '0;
      for (int k = 0; k < KTAPS; k++) w[k] <= '0;
    end else begin
      if (accept) begin
        offs <= '{ifm: ifm_offset_i, wt: wt_offset_i, ofm: ofm_offset_i};
        n    <= fm_dim_i[7:0];
        widx <= '0;
        acc  <= '0;
      end
      if (state == ST_WT_WAIT && resp) begin
        w[widx] <= mem.resp_data_i;
        widx    <= widx + TAP_W'(1);
      end
      // low 32 bits of the product are sign-agnostic, so plain wrap-around MAC
      if (state == ST_IFM_WAIT && resp) acc <= acc + w[tap] * mem.resp_data_i;
      if (state == ST_WRITE && hs)      acc <= '0;
    end
  end
endmodule

// File: tb/tb_conv_ctrl.sv
// Directed bench for conv_ctrl: a memory responder with configurable stall and
// latency, plus a loop-level convolution model that predicts every request.
module tb_conv_ctrl;
  logic        clk = 1'b0;
  logic        rst, start_i;
  logic [31:0] fm_dim_i, ifm_offset_i, wt_offset_i, ofm_offset_i;
  logic        idle_o, done_o;

  always #5 clk = ~clk;

  conv_ctrl_if bus ();

  conv_ctrl dut (
    .clk(clk), .rst(rst), .start_i(start_i), .fm_dim_i(fm_dim_i),
    .ifm_offset_i(ifm_offset_i), .wt_offset_i(wt_offset_i), .ofm_offset_i(ofm_offset_i),
    .idle_o(idle_o), .done_o(done_o), .mem(bus)
  );

  int vec_cnt = 0, err_cnt = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_rd[$], exp_wr_a[$], exp_wr_d[$];
  logic [31:0] wv [9];
  logic [31:0] fv[$];
  int ready_pct = 100, lat_min = 1, lat_max = 1;
  bit outstanding = 0, stalled = 0, chk_done = 0;
  int lat_cnt = 0;
  logic [31:0] rd_addr, st_addr, st_wdata;
  logic st_we;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] addr);
    vec_cnt++;
    err_cnt++;
    $display("FAIL %s: request at 0x%0h, required none", name, addr);
  endtask

  task automatic tick(input int k = 1);
    repeat (k) @(negedge clk);
    #1;
  endtask

  // memory responder: decides ready at each negedge, so a handshake is known
  // before the posedge it happens on
  initial begin
    bus.req_ready_i  = 1'b0;
    bus.resp_valid_i = 1'b0;
    bus.resp_data_i  = '0;
    forever begin
      @(negedge clk);
      bus.resp_valid_i = 1'b0;
      if (chk_done) begin
        chk_done = 0;
        check("done_after_last_write", 32'(done_o), 32'd1);
      end
      if (outstanding) begin
        check("no_req_while_outstanding", 32'(bus.req_valid_o), 32'd0);
        lat_cnt--;
        if (lat_cnt == 0) begin
          bus.resp_valid_i = 1'b1;
          bus.resp_data_i  = mem.exists(rd_addr) ? mem[rd_addr] : 32'd0;
          outstanding      = 0;
        end
      end
      if (stalled) begin
        check("stall_valid", 32'(bus.req_valid_o), 32'd1);
        check("stall_addr",  bus.req_addr_o, st_addr);
        check("stall_we",    32'(bus.req_we_o), 32'(st_we));
        check("stall_wdata", bus.req_wdata_o, st_wdata);
      end
      bus.req_ready_i = ($urandom_range(99, 0) < 32'(ready_pct));
      stalled  = bus.req_valid_o && !bus.req_ready_i;
      st_addr  = bus.req_addr_o;
      st_we    = bus.req_we_o;
      st_wdata = bus.req_wdata_o;
      if (bus.req_valid_o && bus.req_ready_i) begin
        if (bus.req_we_o) begin
          if (exp_wr_a.size() == 0) flag("unexpected_write", bus.req_addr_o);
          else begin
            check("wr_addr", bus.req_addr_o, exp_wr_a.pop_front());
            check("wr_data", bus.req_wdata_o, exp_wr_d.pop_front());
            if (exp_wr_a.size() == 0) chk_done = 1;
          end
        end else begin
          if (exp_rd.size() == 0) flag("unexpected_read", bus.req_addr_o);
          else check("rd_addr", bus.req_addr_o, exp_rd.pop_front());
          outstanding = 1;
          rd_addr     = bus.req_addr_o;
          lat_cnt     = int'($urandom_range(32'(lat_max), 32'(lat_min)));
        end
      end
    end
  end

  // straightforward nested-loop convolution: fills memory and predicts the
  // exact read-address sequence and write stream
  task automatic load_model(input int n, input logic [31:0] io, input logic [31:0] wo,
                            input logic [31:0] oo);
    exp_rd.delete(); exp_wr_a.delete(); exp_wr_d.delete(); mem.delete();
    for (int k = 0; k < 9; k++) begin
      mem[wo + 32'(4 * k)] = wv[k];
      exp_rd.push_back(wo + 32'(4 * k));
    end
    for (int e = 0; e < n * n; e++) mem[io + 32'(4 * e)] = fv[e];
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        logic [31:0] a;
        a = '0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int i, j;
            i = r + dr;
            j = c + dc;
            if (i >= 0 && i < n && j >= 0 && j < n) begin
              exp_rd.push_back(io + 32'(4 * (i * n + j)));
              a = a + wv[(dr + 1) * 3 + dc + 1] * fv[i * n + j];
            end
          end
        end
        exp_wr_a.push_back(oo + 32'(4 * (r * n + c)));
        exp_wr_d.push_back(a);
      end
    end
  endtask

  task automatic run(input string tag, input int n, input logic [31:0] io,
                     input logic [31:0] wo, input logic [31:0] oo, input bit disturb);
    int t;
    fm_dim_i = 32'(n); ifm_offset_i = io; wt_offset_i = wo; ofm_offset_i = oo;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check({tag, "_busy"}, 32'(idle_o), 32'd0);
    if (disturb) begin
      tick(7);
      start_i = 1'b1; fm_dim_i = 32'd2; ifm_offset_i = 32'h5000; ofm_offset_i = 32'h6000;
      tick();
      start_i = 1'b0;
    end
    t = 0;
    while (!(exp_wr_a.size() == 0 && done_o) && t < 5000) begin
      tick();
      t++;
    end
    check({tag, "_done"}, 32'(done_o), 32'd1);
    check({tag, "_idle"}, 32'(idle_o), 32'd1);
    check({tag, "_reads_left"}, 32'(exp_rd.size()), 32'd0);
    check({tag, "_writes_left"}, 32'(exp_wr_a.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    logic [31:0] n3_exp [9];
    rst = 1'b1; start_i = 1'b0; fm_dim_i = '0;
    ifm_offset_i = '0; wt_offset_i = '0; ofm_offset_i = '0;
    tick(2);
    check("rst_idle",  32'(idle_o), 32'd1);
    check("rst_done",  32'(done_o), 32'd0);
    check("rst_valid", 32'(bus.req_valid_o), 32'd0);
    check("rst_we",    32'(bus.req_we_o), 32'd0);
    check("rst_addr",  bus.req_addr_o, 32'd0);
    check("rst_wdata", bus.req_wdata_o, 32'd0);
    rst = 1'b0;
    tick();

    // N=1: only the centre tap is inside the map
    for (int k = 0; k < 9; k++) wv[k] = 32'd0;
    wv[4] = 32'd3;
    fv = {32'd7};
    load_model(1, 32'h1000, 32'h2000, 32'h3000);
    check("model_n1_reads", 32'(exp_rd.size()), 32'd10);
    check("model_n1_data", exp_wr_d[0], 32'd21);
    run("n1", 1, 32'h1000, 32'h2000, 32'h3000, 1'b0);

    // N=3, unit kernel; started from DONE
    for (int k = 0; k < 9; k++) wv[k] = 32'd1;
    fv = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9};
    n3_exp = '{32'd12, 32'd21, 32'd16, 32'd27, 32'd45, 32'd33, 32'd24, 32'd39, 32'd28};
    load_model(3, 32'h1000, 32'h2000, 32'h3000);
    for (int k = 0; k < 9; k++) check("model_n3_data", exp_wr_d[k], n3_exp[k]);
    run("n3", 3, 32'h1000, 32'h2000, 32'h3000, 1'b0);

    // same map under backpressure and variable read latency
    ready_pct = 30; lat_min = 1; lat_max = 5;
    load_model(3, 32'h4000, 32'h4400, 32'h4800);
    run("n3_stall", 3, 32'h4000, 32'h4400, 32'h4800, 1'b0);

    // start pulse mid-run must be ignored
    ready_pct = 100; lat_min = 2; lat_max = 2;
    load_model(3, 32'h1000, 32'h2000, 32'h3000);
    run("n3_disturb", 3, 32'h1000, 32'h2000, 32'h3000, 1'b1);

    // negative weights, output addresses wrapping past 2^32
    for (int k = 0; k < 9; k++) wv[k] = 32'hFFFF_FFFE;
    fv = {32'd1, 32'd2, 32'd3, 32'd4};
    load_model(2, 32'hFFFF_FFFC, 32'h0100, 32'hFFFF_FFF8);
    check("model_n2_data", exp_wr_d[3], 32'hFFFF_FFEC);
    check("model_n2_wrap", exp_wr_a[3], 32'h0000_0004);
    run("n2_wrap", 2, 32'hFFFF_FFFC, 32'h0100, 32'hFFFF_FFF8, 1'b0);

    // N=5, mixed-sign kernel and data
    ready_pct = 50; lat_min = 1; lat_max = 3;
    wv = '{32'd1, -32'sd1, 32'd2, -32'sd2, 32'd3, -32'sd3, 32'd4, -32'sd4, 32'd5};
    fv.delete();
    for (int e = 0; e < 25; e++) fv.push_back(32'(e * 37 - 100));
    load_model(5, 32'h8000, 32'h9000, 32'hA000);
    run("n5", 5, 32'h8000, 32'h9000, 32'hA000, 1'b0);

    // N=0: straight to DONE, no traffic
    ready_pct = 100; lat_min = 1; lat_max = 1;
    exp_rd.delete(); exp_wr_a.delete(); exp_wr_d.delete();
    fm_dim_i = 32'h0000_0100;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("n0_done", 32'(done_o), 32'd1);
    check("n0_idle", 32'(idle_o), 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("n0_no_req", 32'(bus.req_valid_o), 32'd0);
    end

    // reset wins over a simultaneous start
    rst = 1'b1; start_i = 1'b1; fm_dim_i = 32'd3;
    tick();
    rst = 1'b0; start_i = 1'b0;
    check("rst_start_idle", 32'(idle_o), 32'd1);
    check("rst_start_done", 32'(done_o), 32'd0);
    tick();
    check("rst_start_valid", 32'(bus.req_valid_o), 32'd0);

    // reset while an ifm read is outstanding; its late response must be ignored
    lat_min = 4; lat_max = 4;
    for (int k = 0; k < 9; k++) wv[k] = 32'd1;
    fv = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9};
    load_model(3, 32'h1000, 32'h8000, 32'h3000);
    fm_dim_i = 32'd3; ifm_offset_i = 32'h1000; wt_offset_i = 32'h8000; ofm_offset_i = 32'h3000;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    t = 0;
    while (!(outstanding && rd_addr < 32'h8000) && t < 500) begin
      tick();
      t++;
    end
    check("midrst_reached_ifm_read", 32'(t < 500), 32'd1);
    tick();
    rst = 1'b1;
    exp_rd.delete(); exp_wr_a.delete(); exp_wr_d.delete();
    tick();
    rst = 1'b0;
    check("midrst_idle",  32'(idle_o), 32'd1);
    check("midrst_done",  32'(done_o), 32'd0);
    check("midrst_valid", 32'(bus.req_valid_o), 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("midrst_quiet", 32'(bus.req_valid_o), 32'd0);
      check("midrst_stay_idle", 32'(idle_o), 32'd1);
    end

    // fresh run after the abandoned one
    lat_min = 1; lat_max = 1;
    for (int k = 0; k < 9; k++) wv[k] = 32'd0;
    wv[4] = 32'd3;
    fv = {32'd7};
    load_model(1, 32'h1000, 32'h2000, 32'h3000);
    run("post_rst", 1, 32'h1000, 32'h2000, 32'h3000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
